// File: rtl/jts16_irq_ctrl_pkg.sv
// Shared constants and helpers for the System 16 68000 interrupt controller.
// The level map packs 3-bit IPL fields. lvl_of() extracts the field for source i.
package jts16_irq_pkg;

    localparam logic [2:0] IPL_NONE = 3'd0;
    localparam logic [2:0] IPL_VBL  = 3'd4;
    localparam logic [2:0] IPL_SND  = 3'd2;
    localparam logic [2:0] FC_IACK  = 3'b111;

    // The map is zero-extended to 24 bits so that any NSRC from 1 to 8 fits.
    function automatic logic [2:0] lvl_of(input logic [23:0] map, input int i);
        return map[3*i +: 3];
    endfunction

endpackage

// File: rtl/jts16_irq_ctrl_if.sv
// 68000 interrupt-side bus: address strobe, function code and A[3:1] from the CPU;
// the encoded IPL and the auto-vector (VPAn) request back to it.
interface jts16_irq_ctrl_if;

    logic       ASn;
    logic [2:0] FC;
    logic [2:0] A;
    logic [2:0] IPLn;
    logic       inta_n;

    modport master (output ASn, FC, A, input IPLn, inta_n);
    modport slave  (input ASn, FC, A, output IPLn, inta_n);

endinterface

// File: rtl/jts16_irq_ctrl_prio.sv
// Priority resolver. It returns the highest IPL level among the active sources and
// a one-hot select of the lowest-index active source at the level sel_lvl.
module jts16_irq_prio
    import jts16_irq_pkg::*;
#(
    parameter int                NSRC    = 4,
    parameter logic [3*NSRC-1:0] LVL_MAP = 12'o4321
)(
    input  logic [NSRC-1:0] active,
    input  logic [2:0]      sel_lvl,
    output logic [2:0]      max_lvl,
    output logic [NSRC-1:0] sel
);

    logic [2:0] lv;
    logic       found;

    always_comb begin
        max_lvl = IPL_NONE;
        sel     = '0;
        lv      = IPL_NONE;
        found   = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            lv = lvl_of(24'(LVL_MAP), i);
            if (active[i] && lv > max_lvl)
                max_lvl = lv;
            // A level-0 source is disabled, so an acknowledge can never select it.
            if (active[i] && !found && lv == sel_lvl && lv != IPL_NONE) begin
                sel[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/jts16_irq_ctrl.sv
// 68000 interrupt controller with NSRC sources. Each source is edge-latched or
// level-sensitive and can be masked. The CPU acknowledges through the auto-vector.
module jts16_irq_ctrl
    import jts16_irq_pkg::*;
#(
    parameter int                NSRC    = 4,
    parameter logic [3*NSRC-1:0] LVL_MAP = 12'o4321,
    parameter logic [NSRC-1:0]   EDGE    = 4'b1111
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NSRC-1:0] src,
    input  logic [NSRC-1:0] mask,
    jts16_irq_ctrl_if.slave cpu,
    output logic [NSRC-1:0] pend,
    output logic [7:0]      ack_cnt
);

    logic [NSRC-1:0] src_d;
    logic [NSRC-1:0] pend_q;
    logic [NSRC-1:0] active;
    logic [NSRC-1:0] set;
    logic [NSRC-1:0] clr;
    logic [NSRC-1:0] sel;
    logic [2:0]      lvl;
    logic            inta_d;
    logic            iack_stb;

    assign cpu.inta_n = !(cpu.FC == FC_IACK && !cpu.ASn);
    // inta_d resets to 1. An IACK that is still open when reset is released
    // therefore produces one new strobe.
    assign iack_stb   = !cpu.inta_n && inta_d;

    // Level sources bypass the latch. Masking only hides a source; it does not clear it.
    assign pend   = (pend_q & EDGE) | (src & ~EDGE);
    assign active = pend & ~mask;
    assign set    = src & ~src_d & ~mask;
    assign clr    = {NSRC{iack_stb}} & sel;

    jts16_irq_prio #(
        .NSRC    (NSRC),
        .LVL_MAP (LVL_MAP)
    ) u_prio (
        .active  (active),
        .sel_lvl (cpu.A),
        .max_lvl (lvl),
        .sel     (sel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_d    <= '0;
            pend_q   <= '0;
            inta_d   <= 1'b1;
            cpu.IPLn <= 3'b111;
            ack_cnt  <= 8'd0;
        end else begin
            src_d    <= src;
            inta_d   <= cpu.inta_n;
            // A new edge takes priority over a clear in the same cycle, so the event is kept.
            pend_q   <= (set | (pend_q & ~clr)) & EDGE;
            cpu.IPLn <= ~lvl;
            if (iack_stb)
                ack_cnt <= ack_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_jts16_irq_ctrl.sv
// Bench for jts16_irq_ctrl. It drives two instances (all edge sources, and EDGE=4'b1110)
// with the same stimulus and checks both against an event-level reference model.
module tb_jts16_irq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] src, mask;
    logic       asn;
    logic [2:0] fc, a;
    logic [3:0] pend0, pend1;
    logic [7:0] ack0, ack1;
    int         n_cmp = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    jts16_irq_ctrl_if if0 ();
    jts16_irq_ctrl_if if1 ();
    assign if0.ASn = asn;
    assign if0.FC  = fc;
    assign if0.A   = a;
    assign if1.ASn = asn;
    assign if1.FC  = fc;
    assign if1.A   = a;

    jts16_irq_ctrl dut0 (
        .clk(clk), .rst_n(rst_n), .src(src), .mask(mask), .cpu(if0), .pend(pend0), .ack_cnt(ack0)
    );
    jts16_irq_ctrl #(.NSRC(4), .LVL_MAP(12'o4321), .EDGE(4'b1110)) dut1 (
        .clk(clk), .rst_n(rst_n), .src(src), .mask(mask), .cpu(if1), .pend(pend1), .ack_cnt(ack1)
    );

    // Reference model. It tracks the latched events, the previous inputs and the outputs.
    localparam logic [3:0] EDGE_CFG [2] = '{4'b1111, 4'b1110};
    localparam logic [2:0] LVL      [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
    logic [3:0] m_pe  [2];
    logic [2:0] m_ipl [2];
    logic [3:0] m_sd;
    logic       m_id;
    logic [7:0] m_ack;

    function automatic logic [3:0] mpend(int k);
        logic [3:0] p;
        for (int i = 0; i < 4; i++)
            p[i] = EDGE_CFG[k][i] ? m_pe[k][i] : src[i];
        return p;
    endfunction

    task automatic model_reset();
        m_pe[0] = '0; m_pe[1] = '0; m_ipl[0] = 3'b111; m_ipl[1] = 3'b111;
        m_sd = '0; m_id = 1'b1; m_ack = 8'd0;
    endtask

    // Advance one clock. The model computes the next state from the values present
    // before the edge, and the new state is committed 1 time unit after the edge.
    task automatic tick();
        logic       iack_now, stb;
        logic [3:0] p, nxt [2];
        logic [2:0] lv, nipl [2];
        int         hit;
        iack_now = (fc == 3'b111) && !asn;
        stb      = iack_now && m_id;
        for (int k = 0; k < 2; k++) begin
            p = mpend(k); lv = 3'd0; hit = -1;
            for (int i = 0; i < 4; i++)
                if (p[i] && !mask[i]) begin
                    if (LVL[i] > lv) lv = LVL[i];
                    if (hit < 0 && LVL[i] == a) hit = i;
                end
            nxt[k] = m_pe[k];
            for (int i = 0; i < 4; i++)
                if (EDGE_CFG[k][i]) begin
                    if (src[i] && !m_sd[i] && !mask[i]) nxt[k][i] = 1'b1;
                    else if (stb && hit == i)           nxt[k][i] = 1'b0;
                end
            nipl[k] = ~lv;
        end
        @(posedge clk);
        #1;
        m_pe[0] = nxt[0]; m_pe[1] = nxt[1]; m_ipl[0] = nipl[0]; m_ipl[1] = nipl[1];
        m_sd = src; m_id = !iack_now;
        if (stb) m_ack = m_ack + 8'd1;
    endtask

    task automatic iack(input logic [2:0] lvl);
        asn = 1'b0; fc = 3'b111; a = lvl;
        tick();
        asn = 1'b1; fc = 3'b000;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; src = '0; mask = '0; asn = 1'b1; fc = 3'b000; a = 3'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        n_cmp++; if (if0.IPLn !== 3'b111) begin n_fail++; $display("FAIL rst_ipl: got %b want 111", if0.IPLn); end
        n_cmp++; if (pend0 !== 4'b0000)   begin n_fail++; $display("FAIL rst_pend: got %b want 0000", pend0); end
        n_cmp++; if (ack0 !== 8'd0)       begin n_fail++; $display("FAIL rst_ack: got %0d want 0", ack0); end
        n_cmp++; if (if0.inta_n !== 1'b1) begin n_fail++; $display("FAIL rst_inta: got %b want 1", if0.inta_n); end
        rst_n = 1'b1;
        tick(); tick();
        n_cmp++; if (if1.IPLn !== 3'b111) begin n_fail++; $display("FAIL idle_ipl1: got %b want 111", if1.IPLn); end
    endtask

    task automatic test_latency();
        src = 4'b1000;
        tick();
        src = 4'b0000;
        n_cmp++; if (pend0[3] !== 1'b1)   begin n_fail++; $display("FAIL lat_pend: got %b want 1", pend0[3]); end
        n_cmp++; if (if0.IPLn !== 3'b111) begin n_fail++; $display("FAIL lat_ipl_n1: got %b want 111", if0.IPLn); end
        tick();
        n_cmp++; if (if0.IPLn !== 3'b011) begin n_fail++; $display("FAIL lat_ipl_n2: got %b want 011", if0.IPLn); end
    endtask

    task automatic test_ack();
        src = 4'b0001; tick();
        src = 4'b0000; tick();
        n_cmp++; if (if0.IPLn !== 3'b011) begin n_fail++; $display("FAIL ack_pre_ipl: got %b want 011", if0.IPLn); end
        asn = 1'b0; fc = 3'b111; a = 3'd4;
        tick();
        n_cmp++; if (if0.inta_n !== 1'b0) begin n_fail++; $display("FAIL ack_inta: got %b want 0", if0.inta_n); end
        n_cmp++; if (pend0 !== 4'b0001)   begin n_fail++; $display("FAIL ack_pend: got %b want 0001", pend0); end
        n_cmp++; if (ack0 !== 8'd1)       begin n_fail++; $display("FAIL ack_cnt: got %0d want 1", ack0); end
        asn = 1'b1; fc = 3'b000;
        tick();
        n_cmp++; if (if0.IPLn !== 3'b110) begin n_fail++; $display("FAIL ack_post_ipl: got %b want 110", if0.IPLn); end
        iack(3'd1);
        n_cmp++; if (pend0 !== 4'b0000)   begin n_fail++; $display("FAIL ack_clr0: got %b want 0000", pend0); end
    endtask

    task automatic test_back_to_back();
        src = 4'b1000; tick();
        src = 4'b0000; tick();
        src = 4'b1000; asn = 1'b0; fc = 3'b111; a = 3'd4;
        tick();
        n_cmp++; if (pend0[3] !== 1'b1)   begin n_fail++; $display("FAIL coll_pend: got %b want 1", pend0[3]); end
        src = 4'b0000; asn = 1'b1; fc = 3'b000;
        tick();
        n_cmp++; if (if0.IPLn !== 3'b011) begin n_fail++; $display("FAIL coll_ipl_a: got %b want 011", if0.IPLn); end
        tick();
        n_cmp++; if (if0.IPLn !== 3'b011) begin n_fail++; $display("FAIL coll_ipl_b: got %b want 011", if0.IPLn); end
        iack(3'd4);
        n_cmp++; if (pend0 !== 4'b0000)   begin n_fail++; $display("FAIL coll_clr: got %b want 0000", pend0); end
    endtask

    task automatic test_mask();
        mask = 4'b0100; src = 4'b0100; tick();
        src = 4'b0000; tick(); tick();
        n_cmp++; if (pend0[2] !== 1'b0)   begin n_fail++; $display("FAIL mask_drop: got %b want 0", pend0[2]); end
        n_cmp++; if (if0.IPLn !== 3'b111) begin n_fail++; $display("FAIL mask_ipl: got %b want 111", if0.IPLn); end
        mask = 4'b0000; src = 4'b0010; tick();
        src = 4'b0000; tick();
        mask = 4'b0010; tick(); tick();
        n_cmp++; if (pend0[1] !== 1'b1)   begin n_fail++; $display("FAIL mask_keep: got %b want 1", pend0[1]); end
        n_cmp++; if (if0.IPLn !== 3'b111) begin n_fail++; $display("FAIL mask_hide: got %b want 111", if0.IPLn); end
        mask = 4'b0000; tick(); tick();
        n_cmp++; if (if0.IPLn !== 3'b101) begin n_fail++; $display("FAIL mask_restore: got %b want 101", if0.IPLn); end
        iack(3'd2);
    endtask

    task automatic test_level();
        logic [7:0] a0;
        int         n;
        src = 4'b0001; tick(); tick();
        n_cmp++; if (if1.IPLn !== 3'b110) begin n_fail++; $display("FAIL lvl_ipl: got %b want 110", if1.IPLn); end
        a0 = ack1;
        iack(3'd1);
        n_cmp++; if (if1.IPLn !== 3'b110)      begin n_fail++; $display("FAIL lvl_ipl_kept: got %b want 110", if1.IPLn); end
        n_cmp++; if (pend1[0] !== 1'b1)        begin n_fail++; $display("FAIL lvl_pend_kept: got %b want 1", pend1[0]); end
        n_cmp++; if (ack1 !== a0 + 8'd1)       begin n_fail++; $display("FAIL lvl_ack: got %0d want %0d", ack1, a0 + 8'd1); end
        asn = 1'b0; fc = 3'b111; a = 3'd5;
        repeat (10) tick();
        asn = 1'b1; fc = 3'b000; tick();
        n_cmp++; if (ack1 !== a0 + 8'd2)       begin n_fail++; $display("FAIL lvl_long_iack: got %0d want %0d", ack1, a0 + 8'd2); end
        n = 255 - int'(ack0);
        for (int i = 0; i < n; i++) iack(3'd6);
        n_cmp++; if (ack0 !== 8'hFF)           begin n_fail++; $display("FAIL wrap_ff: got %0d want 255", ack0); end
        iack(3'd6);
        n_cmp++; if (ack0 !== 8'h00)           begin n_fail++; $display("FAIL wrap_00: got %0d want 0", ack0); end
        src = 4'b0000; tick();
    endtask

    task automatic test_random();
        int hold = 0;
        for (int c = 0; c < 400; c++) begin
            src  = 4'($urandom_range(0, 15));
            mask = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            if (hold > 0) begin
                hold--;
                if (hold == 0) begin asn = 1'b1; fc = 3'b000; end
            end else if ($urandom_range(0, 5) == 0) begin
                asn = 1'b0; fc = 3'b111; a = 3'($urandom_range(0, 7)); hold = $urandom_range(1, 3);
            end
            tick();
            n_cmp++; if (if0.IPLn !== m_ipl[0]) begin n_fail++; $display("FAIL rnd_ipl0 c%0d: got %b want %b", c, if0.IPLn, m_ipl[0]); end
            n_cmp++; if (if1.IPLn !== m_ipl[1]) begin n_fail++; $display("FAIL rnd_ipl1 c%0d: got %b want %b", c, if1.IPLn, m_ipl[1]); end
            n_cmp++; if (pend0 !== mpend(0))    begin n_fail++; $display("FAIL rnd_pend0 c%0d: got %b want %b", c, pend0, mpend(0)); end
            n_cmp++; if (pend1 !== mpend(1))    begin n_fail++; $display("FAIL rnd_pend1 c%0d: got %b want %b", c, pend1, mpend(1)); end
            n_cmp++; if (ack0 !== m_ack)        begin n_fail++; $display("FAIL rnd_ack0 c%0d: got %0d want %0d", c, ack0, m_ack); end
            n_cmp++; if (ack1 !== m_ack)        begin n_fail++; $display("FAIL rnd_ack1 c%0d: got %0d want %0d", c, ack1, m_ack); end
            n_cmp++; if (if0.inta_n !== !((fc == 3'b111) && !asn))
                begin n_fail++; $display("FAIL rnd_inta c%0d: got %b want %b", c, if0.inta_n, !((fc == 3'b111) && !asn)); end
        end
        asn = 1'b1; fc = 3'b000; src = 4'b0000; mask = 4'b0000;
        tick(); tick();
    endtask

    task automatic test_reset_iack();
        src = 4'b1000; tick();
        src = 4'b0000; tick(); tick();
        #2; asn = 1'b0; fc = 3'b111; a = 3'd3;
        #1; rst_n = 1'b0;
        #1;
        n_cmp++; if (if0.IPLn !== 3'b111) begin n_fail++; $display("FAIL arst_ipl: got %b want 111", if0.IPLn); end
        n_cmp++; if (pend0 !== 4'b0000)   begin n_fail++; $display("FAIL arst_pend: got %b want 0000", pend0); end
        n_cmp++; if (ack0 !== 8'd0)       begin n_fail++; $display("FAIL arst_ack: got %0d want 0", ack0); end
        n_cmp++; if (if0.inta_n !== 1'b0) begin n_fail++; $display("FAIL arst_inta: got %b want 0", if0.inta_n); end
        model_reset();
        @(posedge clk);
        #2; rst_n = 1'b1;
        tick();
        n_cmp++; if (ack0 !== 8'd1)       begin n_fail++; $display("FAIL arst_restrobe: got %0d want 1", ack0); end
        n_cmp++; if (pend0 !== 4'b0000)   begin n_fail++; $display("FAIL arst_noclr: got %b want 0000", pend0); end
        tick(); tick();
        n_cmp++; if (ack0 !== 8'd1)       begin n_fail++; $display("FAIL arst_once: got %0d want 1", ack0); end
        asn = 1'b1; fc = 3'b000; tick();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_ack();
        test_back_to_back();
        test_mask();
        test_level();
        test_random();
        test_reset_iack();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
